// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a one-cycle in-flight tracker and a
// one-entry skid buffer, so stalls from decode never lose or duplicate words
// returned by a synchronous-read instruction memory.
// Optional feature: define FETCH_PERF_EN to add the saturating fetch_bubbles
// counter output.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_bubbles
`endif
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        rsp_valid_q;
  logic        rsp_valid_d;
  logic [31:0] rsp_pc_q;
  logic [31:0] rsp_pc_d;
  logic        skid_valid;
  logic        skid_valid_d;
  logic [31:0] skid_instr;
  logic [31:0] skid_instr_d;
  logic [31:0] skid_pc;
  logic [31:0] skid_pc_d;
  logic [31:0] instr_d;
  logic [31:0] instr_pc_d;
  logic        instr_valid_d;

  assign imem_addr = pc_q;
  assign pc_plus4  = instr_pc + 32'd4;

  // Next-state selection: redirect flushes everything, stall parks the
  // in-flight word in the skid, otherwise issue and advance the outputs.
  always_comb begin
    pc_d          = pc_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_pc_d      = rsp_pc_q;
    skid_valid_d  = skid_valid;
    skid_instr_d  = skid_instr;
    skid_pc_d     = skid_pc;
    instr_d       = instr;
    instr_pc_d    = instr_pc;
    instr_valid_d = instr_valid;

    if (redirect) begin
      pc_d          = redirect_pc & ~32'd3;
      rsp_valid_d   = 1'b0;
      skid_valid_d  = 1'b0;
      instr_valid_d = 1'b0;
    end else if (stall) begin
      rsp_valid_d = 1'b0;
      if (rsp_valid_q && !skid_valid) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc_d    = rsp_pc_q;
      end
    end else begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = pc_q;
      pc_d        = pc_q + 32'd4;
      if (skid_valid) begin
        instr_d       = skid_instr;
        instr_pc_d    = skid_pc;
        instr_valid_d = 1'b1;
        skid_valid_d  = 1'b0;
      end else begin
        instr_d       = imem_rdata;
        instr_pc_d    = rsp_pc_q;
        instr_valid_d = rsp_valid_q;
      end
    end
  end

  // State registers; reset wins over redirect and stall and drops any
  // in-flight or parked instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= 32'd0;
      skid_valid  <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= 32'd0;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      skid_valid  <= skid_valid_d;
      skid_instr  <= skid_instr_d;
      skid_pc     <= skid_pc_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= instr_valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  // Count cycles where decode gets nothing useful, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_bubbles <= 32'd0;
    end else if ((!instr_valid || stall) && (fetch_bubbles != 32'hFFFF_FFFF)) begin
      fetch_bubbles <= fetch_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus for fetch_stage with a scoreboard of
// expected instruction addresses, drained by a monitor whenever decode
// accepts an instruction. Define FETCH_PERF_EN to also check fetch_bubbles.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_bubbles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_bubbles (fetch_bubbles)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory contents: address 0 holds addi x1,x0,5; others a distinct pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then wait until just after the next edge.
  task automatic applyStimulus(input logic r, input logic s, input logic rd,
                               input logic [31:0] rpc);
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  // Monitor: an instruction is consumed at the coming edge when it is valid
  // and decode is neither stalled nor being flushed.
  always @(negedge clk) begin
    if (rst === 1'b0 && redirect === 1'b0 && stall === 1'b0 && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL sb_unexpected: got instr_pc %h, expected no instruction", instr_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checkOutput("sb_pc", instr_pc, e);
        checkOutput("sb_instr", instr, mem_word(e));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("reset_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("reset_instr", instr, 32'h0000_0013);
    checkOutput("reset_pc", instr_pc, 32'd0);

    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd16);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("startup_e1_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("startup_e2_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("startup_e2_instr", instr, 32'h0050_0093);
    checkOutput("startup_e2_pc", instr_pc, 32'd0);
    checkOutput("startup_e2_plus4", pc_plus4, 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("seq_pc4", instr_pc, 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("seq_pc8", instr_pc, 32'd8);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("stall_pc_frozen", instr_pc, 32'd8);
      checkOutput("stall_valid_held", {31'd0, instr_valid}, 32'd1);
`ifdef FETCH_PERF_EN
      if (i == 1) checkOutput("perf_bubbles", fetch_bubbles, 32'd4);
`endif
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("release_pc12", instr_pc, 32'd12);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("release_pc16", instr_pc, 32'd16);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("release_pc20", instr_pc, 32'd20);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    checkOutput("redirect_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("redirect_stall_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("redirect_stall_pc_held", instr_pc, 32'd20);
    exp_q.push_back(32'h0000_0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("redirect_f1_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("redirect_f2_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("redirect_f2_pc", instr_pc, 32'h0000_0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("redirect_f3_pc", instr_pc, 32'h0000_0104);

    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    checkOutput("wrap_redirect_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("wrap_pc_fff8", instr_pc, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("wrap_pc_fffc", instr_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", pc_plus4, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("wrap_pc_0", instr_pc, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("wrap_pc_4", instr_pc, 32'd4);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("skid_fill_pc_held", instr_pc, 32'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("midreset_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("midreset_instr", instr, 32'h0000_0013);
    checkOutput("midreset_pc", instr_pc, 32'd0);
    exp_q.push_back(32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("midreset_e1_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("midreset_e2_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("midreset_e2_pc", instr_pc, 32'd0);
    checkOutput("midreset_e2_instr", instr, 32'h0050_0093);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
